// File: rtl/display_capture.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment display: rebuilds the hex
// digits from sampled select/segment lines. Optional macro DP_CAPTURE_EN adds dp capture.
module display_capture #(
  parameter int STABLE_CYCLES  = 2,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cathode,
  input  logic [7:0] segmentin,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] valid,
  output logic       err,
`ifdef DP_CAPTURE_EN
  output logic [3:0] dp,
`endif
  output logic       frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
`ifdef DP_CAPTURE_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
  logic w_unused_dp;
  assign w_unused_dp = segmentin[7];
`endif

  logic [3:0]       r_sel;
  logic [SEG_W-1:0] r_seg;
  logic [3:0]       r_prev_sel;
  logic [SEG_W-1:0] r_prev_seg;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_seen;
  logic [3:0]       r_valid;
  logic             r_err;
  logic             r_frame_done;
  logic [3:0]       r_digit [4];

  logic             w_usable;
  logic             w_same;
  logic             w_capture;
  logic [CW-1:0]    w_count_next;
  logic             w_hit;
  logic [3:0]       w_value;
  logic [3:0]       w_seen_next;

  // Select lines are normalised to active-high at the input register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel <= 4'b0000;
      r_seg <= '1;
    end else begin
      r_sel <= SEL_ACTIVE_LOW ? ~cathode : cathode;
      r_seg <= segmentin[SEG_W-1:0];
    end
  end

  assign w_usable = $onehot(r_sel);
  assign w_same   = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);

  always_comb begin
    w_count_next = '0;
    w_capture    = 1'b0;
    if (w_usable) begin
      if (!w_same) begin
        w_count_next = CW'(1);
        w_capture    = (STABLE_CYCLES == 1);
      end else if (r_count == STABLE_C) begin
        w_count_next = r_count;
      end else begin
        w_count_next = r_count + CW'(1);
        w_capture    = (w_count_next == STABLE_C);
      end
    end
  end

  always_comb begin
    w_hit   = 1'b1;
    w_value = 4'h0;
    case (r_seg[6:0])
      7'h40: w_value = 4'h0;
      7'h79: w_value = 4'h1;
      7'h24: w_value = 4'h2;
      7'h30: w_value = 4'h3;
      7'h19: w_value = 4'h4;
      7'h12: w_value = 4'h5;
      7'h02: w_value = 4'h6;
      7'h78: w_value = 4'h7;
      7'h00: w_value = 4'h8;
      7'h10: w_value = 4'h9;
      7'h08: w_value = 4'hA;
      7'h03: w_value = 4'hB;
      7'h46: w_value = 4'hC;
      7'h21: w_value = 4'hD;
      7'h06: w_value = 4'hE;
      7'h0E: w_value = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  // r_sel is one-hot whenever a capture fires, so it doubles as the slot mask.
  assign w_seen_next = r_seen | r_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_sel   <= 4'b0000;
      r_prev_seg   <= '1;
      r_count      <= '0;
      r_seen       <= 4'b0000;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_prev_sel   <= r_sel;
      r_prev_seg   <= r_seg;
      r_count      <= w_count_next;
      r_err        <= w_capture && !w_hit;
      r_frame_done <= w_capture && (w_seen_next == 4'hF);
      if (w_capture) begin
        r_seen <= (w_seen_next == 4'hF) ? 4'h0 : w_seen_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (reset) begin
          r_digit[gi] <= 4'h0;
          r_valid[gi] <= 1'b0;
        end else if (w_capture && r_sel[gi]) begin
          r_valid[gi] <= w_hit;
          if (w_hit) begin
            r_digit[gi] <= w_value;
          end
        end
      end
`ifdef DP_CAPTURE_EN
      logic r_dp;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dp <= 1'b0;
        end else if (w_capture && r_sel[gi]) begin
          r_dp <= ~r_seg[7];
        end
      end
      assign dp[gi] = r_dp;
`endif
    end
  endgenerate

  assign digit1     = r_digit[0];
  assign digit2     = r_digit[1];
  assign digit3     = r_digit[2];
  assign digit4     = r_digit[3];
  assign valid      = r_valid;
  assign err        = r_err;
  assign frame_done = r_frame_done;

endmodule
